// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encodings and default frame constants.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;

  localparam int DEF_OVS    = 16;
  localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with registered head, flags and occupancy count.
// A write while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  rdata_q, rdata_d;
  logic          empty_q, empty_d, full_q, full_d;
  logic          pop_ok, wr_ok;

  always_comb begin
    pop_ok   = pop && !empty_q;
    wr_ok    = push && (!full_q || pop_ok);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_ok && !pop_ok) count_d = count_q + 1'b1;
    else if (!wr_ok && pop_ok) count_d = count_q - 1'b1;
    // Head is looked up from next-state memory so rdata stays a plain flop.
    rdata_d = mem_d[rd_ptr_d];
    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  assign rdata = rdata_q;
  assign empty = empty_q;
  assign full  = full_q;
  assign count = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver feeding a show-ahead RX FIFO, with false-start, framing and overrun detection.
// Optional parity check enabled by defining UART_PARITY_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int OVS           = DEF_OVS,
  parameter int CLKS_PER_TICK = 4,
  parameter int FIFO_DEPTH    = 8,
  parameter int PARITY_ODD    = 0
) (
  input  logic                          CLK,
  input  logic                          reset,
  input  logic                          rx_enable,
  input  logic                          rx_in,
  input  logic                          uld_rx_data,
  output logic [DATA_W-1:0]             rx_data,
  output logic                          rx_empty,
  output logic                          rx_full,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          rx_overrun,
  output logic                          frame_err,
  output logic                          parity_err
);

  localparam int TW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam int OW = $clog2(OVS);
  localparam int BW = $clog2(DATA_W);

  uart_state_t       state_q, state_d;
  logic              rx_s1_q, rx_s2_q;
  logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
  logic              tick, ovs_end;
  logic [OW-1:0]     ovs_cnt_q, ovs_cnt_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_bad_q, par_bad_d;
  logic              push_q, push_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
`ifdef UART_PARITY_EN
  logic              parity_err_q, parity_err_d;
`endif

  always_comb begin
    tick       = 1'b0;
    tick_cnt_d = '0;
    if (rx_enable) begin
      if (tick_cnt_q == TW'(CLKS_PER_TICK - 1)) tick = 1'b1;
      else tick_cnt_d = tick_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    ovs_cnt_d   = ovs_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_bad_d   = par_bad_q;
    push_d      = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_PARITY_EN
    parity_err_d = 1'b0;
`endif
    ovs_end = tick && (ovs_cnt_q == OW'(OVS - 1));
    if (tick) ovs_cnt_d = ovs_cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        ovs_cnt_d = '0;
        bit_cnt_d = '0;
        par_bad_d = 1'b0;
        if (!rx_s2_q) state_d = START;
      end
      START: begin
        // Mid-bit recheck rejects glitches shorter than half a bit.
        if (tick && (ovs_cnt_q == OW'(OVS / 2 - 1))) begin
          ovs_cnt_d = '0;
          state_d   = rx_s2_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (ovs_end) begin
          ovs_cnt_d = '0;
          shift_d   = {rx_s2_q, shift_q[DATA_W-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BW'(DATA_W - 1)) begin
`ifdef UART_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (ovs_end) begin
          ovs_cnt_d = '0;
          state_d   = STOP;
          if (rx_s2_q != ((^shift_q) ^ PARITY_ODD[0])) begin
            par_bad_d    = 1'b1;
            parity_err_d = 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (ovs_end) begin
          state_d = IDLE;
          if (rx_s2_q) push_d = !par_bad_q;
          else frame_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!rx_enable) begin
      state_d     = IDLE;
      push_d      = 1'b0;
      frame_err_d = 1'b0;
`ifdef UART_PARITY_EN
      parity_err_d = 1'b0;
`endif
    end
    // Overrun is sticky until the receiver is disabled.
    overrun_d = rx_enable && (overrun_q ||
                (push_q && rx_full && !(uld_rx_data && !rx_empty)));
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      tick_cnt_q  <= '0;
      ovs_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_bad_q   <= 1'b0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rx_s1_q     <= rx_in;
      rx_s2_q     <= rx_s1_q;
      tick_cnt_q  <= tick_cnt_d;
      ovs_cnt_q   <= ovs_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_bad_q   <= par_bad_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK   (CLK),
    .reset (reset),
    .push  (push_q),
    .wdata (shift_q),
    .pop   (uld_rx_data),
    .rdata (rx_data),
    .empty (rx_empty),
    .full  (rx_full),
    .count (rx_count)
  );

  assign rx_overrun = overrun_q;
  assign frame_err  = frame_err_q;
`ifdef UART_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at default parameters (64 CLK per bit) with a byte scoreboard.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int BIT_CLKS = 64;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic       rx_enable = 1'b0;
  logic       rx_in = 1'b1;
  logic       uld_rx_data = 1'b0;
  logic [7:0] rx_data;
  logic       rx_empty, rx_full;
  logic [3:0] rx_count;
  logic       rx_overrun, frame_err, parity_err;

  int total = 0;
  int bad = 0;
  int fe_cnt = 0, fe_long = 0, pe_cnt = 0, pe_long = 0;
  int fe_base, pe_base;
  logic fe_prev = 1'b0, pe_prev = 1'b0;
  logic [7:0] exp_q[$];

  uart_rx_fifo dut (
    .CLK        (CLK),
    .reset      (reset),
    .rx_enable  (rx_enable),
    .rx_in      (rx_in),
    .uld_rx_data(uld_rx_data),
    .rx_data    (rx_data),
    .rx_empty   (rx_empty),
    .rx_full    (rx_full),
    .rx_count   (rx_count),
    .rx_overrun (rx_overrun),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #5 CLK = ~CLK;

  // Pulse counters: every high cycle is counted, back-to-back highs flag an over-long pulse.
  always @(negedge CLK) begin
    if (frame_err) begin
      fe_cnt = fe_cnt + 1;
      if (fe_prev) fe_long = fe_long + 1;
    end
    fe_prev = frame_err;
    if (parity_err) begin
      pe_cnt = pe_cnt + 1;
      if (pe_prev) pe_long = pe_long + 1;
    end
    pe_prev = parity_err;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_head(input logic [7:0] d, input logic par);
    rx_in = 1'b0;
    cycles(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      cycles(BIT_CLKS);
    end
`ifdef UART_PARITY_EN
    rx_in = par;
    cycles(BIT_CLKS);
`else
    if (par === 1'bx) cycles(0);
`endif
  endtask

  // A low stop bit is released early so the trailing low cannot pass as a new start bit.
  task automatic send_stop(input logic b);
    if (b) begin
      rx_in = 1'b1;
      cycles(BIT_CLKS);
    end else begin
      rx_in = 1'b0;
      cycles(48);
      rx_in = 1'b1;
      cycles(BIT_CLKS - 48);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
    send_head(d, par);
    send_stop(stop);
    cycles(32);
  endtask

  task automatic pop_check(input string tag);
    int n;
    logic [7:0] e;
    n = 0;
    while (rx_empty && n < 2000) begin
      cycles(1);
      n++;
    end
    check({tag, "_wait"}, (n < 2000) ? 32'd1 : 32'd0, 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, rx_data, e);
    end
    uld_rx_data = 1'b1;
    cycles(1);
    uld_rx_data = 1'b0;
  endtask

  initial begin
    #3 reset = 1'b0;
    cycles(3);
    check("rst_data", rx_data, 0);
    check("rst_empty", rx_empty, 1);
    check("rst_full", rx_full, 0);
    check("rst_count", rx_count, 0);
    check("rst_overrun", rx_overrun, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_parity_err", parity_err, 0);
    reset = 1'b1;
    cycles(2);
    rx_enable = 1'b1;
    cycles(BIT_CLKS);

    // 0xA5: not yet visible after start+data, visible by end of stop bit.
    exp_q.push_back(8'hA5);
    send_head(8'hA5, ^8'hA5);
    check("a5_early_empty", rx_empty, 1);
    send_stop(1'b1);
    check("a5_landed_empty", rx_empty, 0);
    check("a5_count", rx_count, 1);
    pop_check("a5_data");
    check("a5_popped_empty", rx_empty, 1);
    cycles(32);

    // Glitch shorter than half a bit.
    fe_base = fe_cnt;
    rx_in = 1'b0;
    cycles(20);
    rx_in = 1'b1;
    cycles(200);
    check("glitch_empty", rx_empty, 1);
    check("glitch_fe", fe_cnt - fe_base, 0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, ^8'h3C);
    pop_check("after_glitch_3c");

    // Framing error: discarded, single-cycle pulse.
    fe_base = fe_cnt;
    send_frame(8'h3C, 1'b0, ^8'h3C);
    cycles(BIT_CLKS);
    check("fe_pulses", fe_cnt - fe_base, 1);
    check("fe_empty", rx_empty, 1);

    // Fill to full, then overrun with a ninth byte.
    for (int i = 1; i <= 8; i++) begin
      exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1, ^(8'(i)));
    end
    check("fill_full", rx_full, 1);
    check("fill_count", rx_count, 8);
    check("fill_no_overrun", rx_overrun, 0);
    send_frame(8'h09, 1'b1, ^8'h09);
    check("ovr_flag", rx_overrun, 1);
    check("ovr_count", rx_count, 8);
    for (int i = 1; i <= 8; i++) pop_check($sformatf("drain_%0d", i));
    check("drain_empty", rx_empty, 1);
    check("drain_count", rx_count, 0);
    check("ovr_sticky", rx_overrun, 1);

    // Disable mid-data of 0xFF.
    rx_in = 1'b0;
    cycles(BIT_CLKS);
    rx_in = 1'b1;
    cycles(3 * BIT_CLKS);
    rx_enable = 1'b0;
    cycles(5);
    check("dis_overrun_clr", rx_overrun, 0);
    cycles(10);
    rx_enable = 1'b1;
    cycles(12 * BIT_CLKS);
    check("dis_no_push", rx_empty, 1);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, ^8'h5A);
    pop_check("reen_5a");

`ifdef UART_PARITY_EN
    pe_base = pe_cnt;
    send_frame(8'h07, 1'b1, 1'b0);
    check("par_bad_pulses", pe_cnt - pe_base, 1);
    check("par_bad_empty", rx_empty, 1);
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    pop_check("par_ok_07");
`else
    check("par_tied_low", pe_cnt, 0);
`endif

    // Reset mid-frame with three bytes queued.
    send_frame(8'h11, 1'b1, ^8'h11);
    send_frame(8'h22, 1'b1, ^8'h22);
    send_frame(8'h33, 1'b1, ^8'h33);
    check("pre_rst_count", rx_count, 3);
    rx_in = 1'b0;
    cycles(BIT_CLKS);
    rx_in = 1'b1;
    cycles(BIT_CLKS + 10);
    #2 reset = 1'b0;
    #1;
    check("arst_data", rx_data, 0);
    check("arst_empty", rx_empty, 1);
    check("arst_full", rx_full, 0);
    check("arst_count", rx_count, 0);
    check("arst_overrun", rx_overrun, 0);
    check("arst_frame_err", frame_err, 0);
    check("arst_parity_err", parity_err, 0);
    exp_q.delete();
    cycles(3);
    reset = 1'b1;
    cycles(2 * BIT_CLKS);
    check("post_rst_empty", rx_empty, 1);

    check("fe_width", fe_long, 0);
    check("pe_width", pe_long, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
